// File: rtl/logical_unit_pipe.sv
// logical_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready on both sides.
// Define LU_FLAGS_EN to add registered zero_flag / parity_flag outputs.
module logical_unit_pipe #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = 16
) (
   input  logic             lu_clk,
   input  logic             lu_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             op_err,
   output logic [CNT_W-1:0] op_count
`ifdef LU_FLAGS_EN
   ,
   output logic             zero_flag,
   output logic             parity_flag
`endif
);

   localparam logic [3:0] OP_OR    = 4'd0;
   localparam logic [3:0] OP_AND   = 4'd1;
   localparam logic [3:0] OP_XOR   = 4'd2;
   localparam logic [3:0] OP_NOR   = 4'd3;
   localparam logic [3:0] OP_NAND  = 4'd4;
   localparam logic [3:0] OP_XNOR  = 4'd5;
   localparam logic [3:0] OP_NOTA  = 4'd6;
   localparam logic [3:0] OP_NOTB  = 4'd7;
   localparam logic [3:0] OP_PASSA = 4'd8;
   localparam logic [3:0] OP_PASSB = 4'd9;
   localparam logic [3:0] OP_ANDN  = 4'd10;
   localparam logic [3:0] OP_ORN   = 4'd11;

   // Stage 1 registers
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;
   logic [3:0]       s1_op_q;

   // Stage 2 registers
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] c_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             s2_take;
   logic             in_fire;
   logic             s1_move;
   logic             out_fire;
   logic [WIDTH-1:0] res_c;
   logic             res_err;

   assign s2_take  = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_take;
   assign in_fire  = in_valid && in_ready;
   assign s1_move  = s1_valid_q && s2_take;
   assign out_fire = out_valid_q && out_ready;

   always_comb begin
      res_c   = '0;
      res_err = 1'b0;
      case (s1_op_q)
         OP_OR:    res_c = s1_a_q | s1_b_q;
         OP_AND:   res_c = s1_a_q & s1_b_q;
         OP_XOR:   res_c = s1_a_q ^ s1_b_q;
         OP_NOR:   res_c = ~(s1_a_q | s1_b_q);
         OP_NAND:  res_c = ~(s1_a_q & s1_b_q);
         OP_XNOR:  res_c = ~(s1_a_q ^ s1_b_q);
         OP_NOTA:  res_c = ~s1_a_q;
         OP_NOTB:  res_c = ~s1_b_q;
         OP_PASSA: res_c = s1_a_q;
         OP_PASSB: res_c = s1_b_q;
         OP_ANDN:  res_c = s1_a_q & ~s1_b_q;
         OP_ORN:   res_c = s1_a_q | ~s1_b_q;
         default:  res_err = 1'b1;
      endcase
   end

   // A new beat may land in S1 in the same cycle the old one moves on.
   always_comb begin
      s1_valid_d = s1_valid_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
      end else if (s1_move) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      if (s1_move) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (out_fire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge lu_clk or negedge lu_rst_n) begin
      if (!lu_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (in_fire) begin
            s1_a_q  <= a;
            s1_b_q  <= b;
            s1_op_q <= opcode;
         end
      end
   end

   always_ff @(posedge lu_clk or negedge lu_rst_n) begin
      if (!lu_rst_n) begin
         out_valid_q <= 1'b0;
         c_q         <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         if (s1_move) begin
            c_q   <= res_c;
            err_q <= res_err;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign c         = c_q;
   assign op_err    = err_q;
   assign op_count  = cnt_q;

`ifdef LU_FLAGS_EN
   logic zero_q;
   logic parity_q;

   // Reserved opcodes yield res_c == 0, so zero=1 / parity=0 fall out naturally.
   always_ff @(posedge lu_clk or negedge lu_rst_n) begin
      if (!lu_rst_n) begin
         zero_q   <= 1'b1;
         parity_q <= 1'b0;
      end else if (s1_move) begin
         zero_q   <= ~|res_c;
         parity_q <= ^res_c;
      end
   end

   assign zero_flag   = zero_q;
   assign parity_flag = parity_q;
`endif

endmodule

// File: tb/tb_logical_unit_pipe.sv
// Bench for logical_unit_pipe: queue-based reference model plus directed vectors.
// Main instance is WIDTH=64/CNT_W=4 (exercises wrap); a second WIDTH=8 instance covers narrow use.
`timescale 1ns/1ps
module tb_logical_unit_pipe;

   localparam int unsigned CW = 4;
   localparam logic [63:0] VA = 64'hF0F0_F0F0_F0F0_F0F0;
   localparam logic [63:0] VB = 64'hFF00_FF00_FF00_FF00;

   logic        lu_clk = 1'b0;
   logic        lu_rst_n = 1'b0;
   always #5 lu_clk = ~lu_clk;

   logic          in_valid, in_ready, out_valid, out_ready, op_err;
   logic [63:0]   a, b, c;
   logic [3:0]    opcode;
   logic [CW-1:0] op_count;

   logic        n_valid, n_ready, n_out_valid, n_out_ready, n_err;
   logic [7:0]  n_a, n_b, n_c;
   logic [3:0]  n_op;
   logic [15:0] n_cnt;
`ifdef LU_FLAGS_EN
   logic zero_flag, parity_flag, n_zero, n_par;
`endif

   logical_unit_pipe #(.WIDTH(64), .CNT_W(CW)) u_dut (
      .lu_clk(lu_clk), .lu_rst_n(lu_rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
      .c(c), .op_err(op_err), .op_count(op_count)
`ifdef LU_FLAGS_EN
      , .zero_flag(zero_flag), .parity_flag(parity_flag)
`endif
   );

   logical_unit_pipe #(.WIDTH(8), .CNT_W(16)) u_nar (
      .lu_clk(lu_clk), .lu_rst_n(lu_rst_n), .in_valid(n_valid), .in_ready(n_ready),
      .a(n_a), .b(n_b), .opcode(n_op), .out_valid(n_out_valid), .out_ready(n_out_ready),
      .c(n_c), .op_err(n_err), .op_count(n_cnt)
`ifdef LU_FLAGS_EN
      , .zero_flag(n_zero), .parity_flag(n_par)
`endif
   );

   typedef struct {
      logic [63:0] c;
      logic        err;
      int unsigned acc;
   } exp_t;

   exp_t        q[$];
   logic [63:0] log_c[$];
   logic        log_err[$];
   int unsigned edge_n = 0;
   int unsigned n_acc = 0;
   int unsigned model_cnt = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   always @(posedge lu_clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                  input logic [3:0] op);
      exp_t e;
      e.err = 1'b0;
      e.acc = 0;
      case (op)
         4'd0:    e.c = x | y;
         4'd1:    e.c = x & y;
         4'd2:    e.c = x ^ y;
         4'd3:    e.c = ~(x | y);
         4'd4:    e.c = ~(x & y);
         4'd5:    e.c = ~(x ^ y);
         4'd6:    e.c = ~x;
         4'd7:    e.c = ~y;
         4'd8:    e.c = x;
         4'd9:    e.c = y;
         4'd10:   e.c = x & ~y;
         4'd11:   e.c = x | ~y;
         default: begin e.c = '0; e.err = 1'b1; end
      endcase
      return e;
   endfunction

   // Sampled mid-cycle: outputs reflect the last edge, handshakes predict the next one.
   always @(negedge lu_clk) begin
      if (!lu_rst_n) begin
         q.delete();
         model_cnt = 0;
      end else begin
         check("out_valid", 64'(out_valid), 64'((q.size() > 0) && (edge_n > q[0].acc)));
         check("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
         check("op_count", 64'(op_count), 64'(model_cnt % (1 << CW)));
         if (out_valid && q.size() > 0) begin
            check("c", c, q[0].c);
            check("op_err", 64'(op_err), 64'(q[0].err));
`ifdef LU_FLAGS_EN
            check("zero_flag", 64'(zero_flag), 64'(q[0].c == 64'd0));
            check("parity_flag", 64'(parity_flag), 64'(^q[0].c));
`endif
         end
         if (out_valid && out_ready && q.size() > 0) begin
            log_c.push_back(c);
            log_err.push_back(op_err);
            void'(q.pop_front());
            model_cnt++;
         end
         if (in_valid && in_ready) begin
            exp_t e;
            e = model(a, b, opcode);
            e.acc = edge_n + 1;
            q.push_back(e);
            n_acc++;
         end
      end
   end

   // Called at posedge+2; returns at posedge+2 after the beat is taken.
   task automatic send(input logic [63:0] ta, input logic [63:0] tb, input logic [3:0] top);
      int n = 0;
      in_valid = 1'b1;
      a = ta;
      b = tb;
      opcode = top;
      do begin
         @(negedge lu_clk);
         n++;
      end while (!in_ready && n < 50);
      if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
      @(posedge lu_clk);
      #2;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge lu_clk);
         n++;
      end
      check("drain_left", 64'(q.size()), 64'd0);
      @(posedge lu_clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned e0;
      int unsigned base;
      in_valid = 0; a = '0; b = '0; opcode = '0; out_ready = 1'b1;
      n_valid = 0; n_a = '0; n_b = '0; n_op = '0; n_out_ready = 1'b1;

      // Reset values
      #3;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_c", c, 64'd0);
      check("rst_op_err", 64'(op_err), 64'd0);
      check("rst_op_count", 64'(op_count), 64'd0);
`ifdef LU_FLAGS_EN
      check("rst_zero", 64'(zero_flag), 64'd1);
      check("rst_parity", 64'(parity_flag), 64'd0);
`endif
      repeat (2) @(posedge lu_clk);
      #1 lu_rst_n = 1'b1;
      @(posedge lu_clk);
      #2;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Narrow instance: 0x5A & 0x0F, then NOR of all-ones
      n_valid = 1'b1; n_a = 8'h5A; n_b = 8'h0F; n_op = 4'd1;
      @(posedge lu_clk); #2;
      n_a = 8'hFF; n_b = 8'hFF; n_op = 4'd3;
      @(posedge lu_clk); #2;
      n_valid = 1'b0;
      @(negedge lu_clk);
      check("nar_valid1", 64'(n_out_valid), 64'd1);
      check("nar_c1", 64'(n_c), 64'h0A);
      check("nar_err1", 64'(n_err), 64'd0);
`ifdef LU_FLAGS_EN
      check("nar_zero1", 64'(n_zero), 64'd0);
      check("nar_par1", 64'(n_par), 64'd0);
`endif
      @(negedge lu_clk);
      check("nar_valid2", 64'(n_out_valid), 64'd1);
      check("nar_c2", 64'(n_c), 64'h00);
`ifdef LU_FLAGS_EN
      check("nar_zero2", 64'(n_zero), 64'd1);
`endif
      @(negedge lu_clk);
      check("nar_valid3", 64'(n_out_valid), 64'd0);
      check("nar_cnt", 64'(n_cnt), 64'd2);
      @(posedge lu_clk); #2;

      // Basic ops 0..11 back-to-back
      log_c.delete(); log_err.delete();
      e0 = edge_n;
      for (int i = 0; i < 12; i++) send(VA, VB, 4'(i));
      check("throughput_edges", 64'(edge_n - e0), 64'd12);
      drain();
      check("basic_count", 64'(log_c.size()), 64'd12);
      if (log_c.size() == 12) begin
         check("op0_or", log_c[0], 64'hFFF0_FFF0_FFF0_FFF0);
         check("op2_xor", log_c[2], 64'h0FF0_0FF0_0FF0_0FF0);
         check("op10_andn", log_c[10], 64'h00F0_00F0_00F0_00F0);
         check("op11_orn", log_c[11], 64'hF0FF_F0FF_F0FF_F0FF);
      end
      check("basic_op_count", 64'(op_count), 64'd12);

      // Backpressure: 4 beats against a stalled sink
      log_c.delete(); log_err.delete();
      base = n_acc;
      out_ready = 1'b0;
      fork
         begin
            send(VA, VB, 4'd2);
            send(VA, VB, 4'd8);
            send(VA, VB, 4'd9);
            send(VA, VB, 4'd1);
         end
         begin
            repeat (5) @(negedge lu_clk);
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_accepted", 64'(n_acc - base), 64'd2);
            check("bp_held_c", c, 64'h0FF0_0FF0_0FF0_0FF0);
            @(posedge lu_clk); #2;
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", 64'(log_c.size()), 64'd4);
      if (log_c.size() == 4) begin
         check("bp_r0", log_c[0], 64'h0FF0_0FF0_0FF0_0FF0);
         check("bp_r1", log_c[1], VA);
         check("bp_r2", log_c[2], VB);
         check("bp_r3", log_c[3], 64'hF000_F000_F000_F000);
      end
      check("bp_op_count_wrap", 64'(op_count), 64'd0);

      // Reserved opcode
      log_c.delete(); log_err.delete();
      send('1, '1, 4'd13);
      drain();
      check("rsv_count", 64'(log_c.size()), 64'd1);
      if (log_c.size() == 1) begin
         check("rsv_c", log_c[0], 64'd0);
         check("rsv_err", 64'(log_err[0]), 64'd1);
      end
      check("rsv_op_count", 64'(op_count), 64'd1);

      // Async reset with both stages full
      out_ready = 1'b0;
      send(VA, VB, 4'd0);
      send(VA, VB, 4'd1);
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      #1 lu_rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_c", c, 64'd0);
      check("arst_op_count", 64'(op_count), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      #2 lu_rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) @(negedge lu_clk);
      #1;
      check("arst_no_stale", 64'(out_valid), 64'd0);
      @(posedge lu_clk); #2;

      // Counter wrap with CNT_W=4
      log_c.delete(); log_err.delete();
      for (int i = 0; i < 16; i++) send(VA ^ 64'(i), VB, 4'(i));
      drain();
      check("wrap_16", 64'(op_count), 64'd0);
      send(VA, VB, 4'd5);
      drain();
      check("wrap_17", 64'(op_count), 64'd1);
      check("wrap_results", 64'(log_c.size()), 64'd17);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/logical_unit_pipe.md
Name: logical_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's 64-bit logical unit.
- Bitwise logic on WIDTH-bit operands, selected by a 4-bit opcode.
- Two register stages with valid/ready handshakes on input and output, so it tolerates backpressure and sustains one operation per cycle.
- Sits between the ALU operand dispatch and the result writeback arbiter.

Parameters:
WIDTH, 64, operand and result width in bits (legal range 1..128)
CNT_W, 16, width of the completed-operation counter

Ports:
lu_clk  input  1  rising-edge clock
lu_rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
opcode  input  4  operation select
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
c  output  WIDTH  result
op_err  output  1  result came from a reserved opcode
op_count  output  CNT_W  number of results accepted downstream
zero_flag  output  1  c == 0 (only when LU_FLAGS_EN is defined)
parity_flag  output  1  XOR-reduction of c (only when LU_FLAGS_EN is defined)

Behaviour:
- Clock and reset: one clock, lu_clk. Reset lu_rst_n is asynchronous, active-low.
- Reset values: out_valid=0, c=0, op_err=0, op_count=0, zero_flag=1, parity_flag=0, internal s1_valid=0. in_ready reads 1 one cycle after reset is released.
- Opcodes:
  - 0 OR, 1 AND, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 ~a, 7 ~b.
  - 8 pass a, 9 pass b, 10 a&~b, 11 a|~b.
  - 12-15 are reserved: c=0, op_err=1.
- Stage 1 (S1):
  - Registers a, b and opcode when in_valid && in_ready.
  - Sets s1_valid.
- Stage 2 (S2):
  - Computes the result from the S1 registers.
  - Registers c, op_err and the flags.
  - Sets out_valid.
- Advance rules:
  - s2_take = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_take. This is combinational, with no dependency on in_valid.
  - S1 moves into S2 when s1_valid && s2_take.
  - out_valid clears when out_ready is high and S1 has nothing to move.
- Latency: 2 cycles from input acceptance to out_valid with no backpressure. Throughput is one beat per cycle.
- Backpressure:
  - While out_valid && !out_ready, c/op_err/flags hold stable.
  - S1 can still fill once. After that in_ready=0 until out_ready.
  - No beat is ever dropped or duplicated.
- Simultaneous events: in the same cycle, output acceptance, S1→S2 transfer and a new input acceptance all occur.
- op_count:
  - Increments on every out_valid && out_ready.
  - Wraps from 2^CNT_W-1 to 0 with no saturation.
  - Reserved-opcode results also count.
- Reset mid-operation: all in-flight beats are discarded immediately. Outputs take reset values asynchronously.
- Width: every operation is bitwise over all WIDTH bits. No carries, no sign handling.

Optional Feature:
- Macro: LU_FLAGS_EN.
- When defined:
  - zero_flag and parity_flag exist.
  - Both are registered in S2 alongside c and held with c under backpressure.
  - For reserved opcodes: zero_flag=1, parity_flag=0.
- When undefined:
  - Both ports are absent.
  - No flag logic is synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset and basic ops, WIDTH=64:
  - Stimulus: reset asserted; then a=0xF0F0_F0F0_F0F0_F0F0, b=0xFF00_FF00_FF00_FF00, opcode 0..11 back-to-back with out_ready=1.
  - Required: results in order, 2 cycles each, e.g. op2 gives 0x0FF0_0FF0_0FF0_0FF0 and op10 gives 0x00F0_00F0_00F0_00F0. op_count ends at 12.
- Backpressure:
  - Stimulus: stream 4 beats with out_ready=0 for 5 cycles.
  - Required: first result held stable. in_ready drops after 2 accepted beats. Releasing out_ready delivers all 4 in order with none lost.
- Reserved opcode:
  - Stimulus: opcode 13, a=b=all ones.
  - Required: c=0, op_err=1, zero_flag=1 (with LU_FLAGS_EN). op_count increments.
- Async reset mid-stream:
  - Stimulus: lu_rst_n pulsed low between clock edges while S1 and S2 are full.
  - Required: out_valid=0 and c=0 immediately. No stale result appears after release.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 accepted results.
  - Required: op_count reads 0 after the 16th and 1 after the 17th.
- Narrow width with flags:
  - Stimulus: WIDTH=8, LU_FLAGS_EN defined, a=0x5A, b=0x0F, op1.
  - Required: c=0x0A, parity_flag=0, zero_flag=0. Then op3 with a=b=0xFF gives c=0x00, zero_flag=1.
